// File: rtl/ha_df.sv
// Registered multi-lane half adder with a saturating carry-event counter.
// Lanes are independent; s/c update only on accepted samples, out_valid pulses per result.
module ha_df #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             out_valid,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             cnt_ovf,
  output logic             any_carry
);

  localparam int unsigned POP_W = $clog2(WIDTH + 1);
  // Headroom so a full-width popcount never overflows the saturation compare.
  localparam int unsigned SUM_W = CNT_W + 7;
  localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(a[i] & b[i]);
    end
    sum = {{(SUM_W - CNT_W){1'b0}}, cnt_q} + SUM_W'(pop);
  end

  always_comb begin
    s_d         = s_q;
    c_d         = c_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      s_d         = a ^ b;
      c_d         = a & b;
      out_valid_d = 1'b1;
    end
  end

  // Clear wins over a same-edge increment; reaching or passing the max flags overflow.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (cnt_clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (in_valid && (pop != '0)) begin
      if (sum >= CNT_MAX) begin
        cnt_d = '1;
        ovf_d = 1'b1;
      end else begin
        cnt_d = sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s_q         <= s_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign s         = s_q;
  assign c         = c_q;
  assign out_valid = out_valid_q;
  assign carry_cnt = cnt_q;
  assign cnt_ovf   = ovf_q;
  assign any_carry = |c_q;

endmodule

// File: tb/tb_ha_df.sv
// Bench for ha_df: a 4-lane/4-bit-counter instance and a 1-lane/16-bit-counter instance
// driven in lockstep; expected results are queued at drive time and checked after the edge.
module tb_ha_df;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a4, b4;
  logic       in_valid, cnt_clr;

  logic [3:0]  s4, c4, cnt4;
  logic        ov4, ovf4, any4;
  logic [0:0]  s1, c1;
  logic [15:0] cnt1;
  logic        ov1, ovf1, any1;

  always #5 clk = ~clk;

  ha_df #(.WIDTH(4), .CNT_W(4)) u_w4 (
    .s(s4), .c(c4), .a(a4), .b(b4), .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .out_valid(ov4), .cnt_clr(cnt_clr),
    .carry_cnt(cnt4), .cnt_ovf(ovf4), .any_carry(any4)
  );

  ha_df #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .s(s1), .c(c1), .a(a4[0:0]), .b(b4[0:0]), .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .out_valid(ov1), .cnt_clr(cnt_clr),
    .carry_cnt(cnt1), .cnt_ovf(ovf1), .any_carry(any1)
  );

  typedef struct {
    logic [3:0]  s, c, cnt;
    logic        ov, any, ovf;
    logic        s1, c1, ovf1;
    logic [15:0] cnt1;
  } exp_t;

  exp_t sb[$];

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [3:0]  m_s, m_c, m_cnt;
  logic        m_ov, m_ovf, m_ovf1;
  logic [15:0] m_cnt1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s = '0; m_c = '0; m_cnt = '0; m_ov = 1'b0; m_ovf = 1'b0;
    m_cnt1 = '0; m_ovf1 = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".s4"}, 32'(s4), 32'd0);
    chk({tag, ".c4"}, 32'(c4), 32'd0);
    chk({tag, ".ov4"}, 32'(ov4), 32'd0);
    chk({tag, ".cnt4"}, 32'(cnt4), 32'd0);
    chk({tag, ".ovf4"}, 32'(ovf4), 32'd0);
    chk({tag, ".any4"}, 32'(any4), 32'd0);
    chk({tag, ".s1c1"}, 32'({s1, c1}), 32'd0);
    chk({tag, ".ov1"}, 32'(ov1), 32'd0);
    chk({tag, ".cnt1"}, 32'(cnt1), 32'd0);
    chk({tag, ".ovf1any1"}, 32'({ovf1, any1}), 32'd0);
  endtask

  task automatic step(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                      input logic tv, input logic tclr);
    exp_t e;
    int   sum;
    a4 = ta; b4 = tb; in_valid = tv; cnt_clr = tclr;
    m_ov = tv;
    if (tv) begin
      m_s = ta ^ tb;
      m_c = ta & tb;
    end
    if (tclr) begin
      m_cnt = '0; m_ovf = 1'b0; m_cnt1 = '0; m_ovf1 = 1'b0;
    end else if (tv) begin
      sum = int'(m_cnt) + $countones(ta & tb);
      if ($countones(ta & tb) != 0 && sum >= 15) m_ovf = 1'b1;
      m_cnt = (sum > 15) ? 4'd15 : 4'(sum);
      sum = int'(m_cnt1) + int'(ta[0] & tb[0]);
      if ((ta[0] & tb[0]) && sum >= 65535) m_ovf1 = 1'b1;
      m_cnt1 = (sum > 65535) ? 16'hFFFF : 16'(sum);
    end
    e.s = m_s; e.c = m_c; e.cnt = m_cnt; e.ov = m_ov; e.any = |m_c; e.ovf = m_ovf;
    e.s1 = m_s[0]; e.c1 = m_c[0]; e.ovf1 = m_ovf1; e.cnt1 = m_cnt1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".s4"}, 32'(s4), 32'(e.s));
    chk({tag, ".c4"}, 32'(c4), 32'(e.c));
    chk({tag, ".ov4"}, 32'(ov4), 32'(e.ov));
    chk({tag, ".any4"}, 32'(any4), 32'(e.any));
    chk({tag, ".cnt4"}, 32'(cnt4), 32'(e.cnt));
    chk({tag, ".ovf4"}, 32'(ovf4), 32'(e.ovf));
    chk({tag, ".s1"}, 32'(s1), 32'(e.s1));
    chk({tag, ".c1"}, 32'(c1), 32'(e.c1));
    chk({tag, ".ov1"}, 32'(ov1), 32'(e.ov));
    chk({tag, ".any1"}, 32'(any1), 32'(e.c1));
    chk({tag, ".cnt1"}, 32'(cnt1), 32'(e.cnt1));
    chk({tag, ".ovf1"}, 32'(ovf1), 32'(e.ovf1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with busy inputs: outputs must be zero before any edge and stay zero.
    rst_n = 1'b0; a4 = 4'hF; b4 = 4'hF; in_valid = 1'b1; cnt_clr = 1'b0;
    model_reset();
    #1;
    check_all_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Single-lane truth table on lane 0, back to back
    step("tt00", 4'b0000, 4'b0000, 1'b1, 1'b0);
    step("tt10", 4'b0001, 4'b0000, 1'b1, 1'b0);
    step("tt11", 4'b0001, 4'b0001, 1'b1, 1'b0);
    step("tt01", 4'b0000, 4'b0001, 1'b1, 1'b0);
    chk("tt01.s_lit", 32'({s1, c1}), 32'b10);

    // Hold for three idle cycles after s=1,c=0
    for (int i = 0; i < 3; i++) step("idle", 4'h0, 4'h0, 1'b0, 1'b0);
    chk("idle.s1_lit", 32'({s1, c1}), 32'b10);
    chk("idle.cnt4_lit", 32'(cnt4), 32'd1);

    // Four-lane vector
    step("vec", 4'b1011, 4'b0110, 1'b1, 1'b0);
    chk("vec.s_lit", 32'(s4), 32'b1101);
    chk("vec.c_lit", 32'(c4), 32'b0010);
    chk("vec.cnt_lit", 32'(cnt4), 32'd2);
    step("vec_end", 4'h0, 4'h0, 1'b0, 1'b0);

    // Clear alone, then saturate the 4-bit counter
    step("clr", 4'h0, 4'h0, 1'b0, 1'b1);
    chk("clr.cnt_lit", 32'(cnt4), 32'd0);
    step("sat1", 4'hF, 4'hF, 1'b1, 1'b0);
    step("sat2", 4'hF, 4'hF, 1'b1, 1'b0);
    step("sat3", 4'hF, 4'hF, 1'b1, 1'b0);
    chk("sat3.lit", 32'({ovf4, cnt4}), 32'h0C);
    step("sat4", 4'hF, 4'hF, 1'b1, 1'b0);
    chk("sat4.lit", 32'({ovf4, cnt4}), 32'h1F);
    step("sat5", 4'hF, 4'hF, 1'b1, 1'b0);
    chk("sat5.lit", 32'({ovf4, cnt4}), 32'h1F);

    // Clear beats a simultaneous carry-producing sample; datapath still updates
    step("clr_inc", 4'hF, 4'hF, 1'b1, 1'b1);
    chk("clr_inc.lit", 32'({ovf4, cnt4, s4, c4}), 32'h00F);

    // Random traffic with occasional clears
    for (int i = 0; i < 16; i++)
      step("rnd", 4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) == 0));

    // Asynchronous reset between edges while a sample is pending
    a4 = 4'hF; b4 = 4'hF; in_valid = 1'b1; cnt_clr = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    check_all_zero("rst_mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step("post_rst", 4'b1011, 4'b0110, 1'b1, 1'b0);
    chk("post_rst.lit", 32'({s4, c4}), 32'hD2);
    step("post_rst_idle", 4'h0, 4'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
